// File: rtl/vector_pkg.sv
// Shared types and constants for the vector store datapath.
package vector_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } vsu_state_t;

  typedef logic [$clog2(LANES)-1:0] lane_idx_t;

endpackage

// File: rtl/lane_priority_encoder.sv
// Combinational lowest-set-bit encoder over the pending lane mask.
module lane_priority_encoder #(
  parameter int LANES = 4,
  parameter int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_store_unit.sv
// Stores one captured multi-lane ALU result to word memory, one enabled lane
// per accepted write, lowest lane first, then pulses done.
module vector_store_unit
  import vector_pkg::*;
#(
  parameter int LANES  = vector_pkg::LANES,
  parameter int LANE_W = vector_pkg::LANE_W,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LANES*LANE_W-1:0] data,
  input  logic [ADDR_W-1:0]       baseAddr,
  input  logic [ADDR_W-1:0]       stride,
  input  logic [LANES-1:0]        laneMask,
  input  logic                    memReady,
  output logic                    memWe,
  output logic [ADDR_W-1:0]       memAddr,
  output logic [LANE_W-1:0]       memWData,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  vsu_state_t              state_q, state_d;
  logic [LANES*LANE_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [ADDR_W-1:0]       stride_q, stride_d;
  logic [LANES-1:0]        pend_q, pend_d;

  logic [IDX_W-1:0]        cur_idx;
  logic                    cur_valid;
  logic [ADDR_W-1:0]       lane_off;
  logic [ADDR_W-1:0]       lane_addr;
  logic [LANE_W-1:0]       lane_data;
  logic                    write_active;

  lane_priority_encoder #(
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_enc (
    .mask  (pend_q),
    .idx   (cur_idx),
    .valid (cur_valid)
  );

  // Current lane address and data; the stride is arbitrary, so a real
  // product is used and the sum wraps silently modulo 2^ADDR_W.
  always_comb begin
    lane_off     = ADDR_W'(cur_idx) * stride_q;
    lane_addr    = base_q + lane_off;
    lane_data    = data_q[cur_idx*LANE_W +: LANE_W];
    write_active = (state_q == WRITE) && cur_valid;
  end

  // Next-state logic: latch operands on start in IDLE, retire one lane per
  // accepted write, single-cycle DONE back to IDLE.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    base_d   = base_q;
    stride_d = stride_q;
    pend_d   = pend_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d   = data;
          base_d   = baseAddr;
          stride_d = stride;
          pend_d   = laneMask;
          state_d  = (laneMask != '0) ? WRITE : DONE;
        end
      end
      WRITE: begin
        if (memReady) begin
          pend_d = pend_q & ~(LANES'(1) << cur_idx);
          if (pend_d == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and operand registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      base_q   <= '0;
      stride_q <= '0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      pend_q   <= pend_d;
    end
  end

  // Outputs decode registered state only; address/data read zero when idle.
  always_comb begin
    memWe    = write_active;
    memAddr  = write_active ? lane_addr : '0;
    memWData = write_active ? lane_data : '0;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

endmodule

// File: tb/tb_vector_store_unit.sv
// Directed table-driven bench for vector_store_unit plus reset sequences.
module tb_vector_store_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] data;
  logic [31:0]  baseAddr;
  logic [31:0]  stride;
  logic [3:0]   laneMask;
  logic         memReady;
  logic         memWe;
  logic [31:0]  memAddr;
  logic [31:0]  memWData;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] VDATA = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  typedef struct packed {
    logic [3:0]       mask;
    logic [31:0]      base;
    logic [31:0]      strd;
    logic [15:0]      stall;
    int               done_k;
    int               nwr;
    logic [3:0][31:0] addr;
    logic [3:0][31:0] wd;
    bit               poke;
  } vec_t;

  vec_t vecs[7];

  vector_store_unit #(.LANES(4), .LANE_W(32), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data     (data),
    .baseAddr (baseAddr),
    .stride   (stride),
    .laneMask (laneMask),
    .memReady (memReady),
    .memWe    (memWe),
    .memAddr  (memAddr),
    .memWData (memWData),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] m, input logic [31:0] b, input logic [31:0] s,
                              input logic [15:0] st, input int dk, input int n,
                              input logic [127:0] a, input logic [127:0] w, input bit p);
    vec_t v;
    v.mask = m; v.base = b; v.strd = s; v.stall = st; v.done_k = dk; v.nwr = n;
    v.addr = a; v.wd = w; v.poke = p;
    return v;
  endfunction

  // Outputs are observed 1 time unit after each rising edge; observation k
  // shows the value present at edge T+k, where T is the edge sampling start.
  task automatic run_vec(input vec_t v, input int id);
    int n;
    string tag;
    data = VDATA; baseAddr = v.base; stride = v.strd; laneMask = v.mask;
    start = 1'b1; memReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      tag = $sformatf("v%0d_k%0d", id, k);
      memReady = ~v.stall[k];
      chk({tag, "_done"}, {31'd0, done}, {31'd0, k == v.done_k});
      chk({tag, "_busy"}, {31'd0, busy}, {31'd0, k <= v.done_k});
      chk({tag, "_we"}, {31'd0, memWe}, {31'd0, k < v.done_k});
      if (memWe && n < v.nwr) begin
        chk({tag, "_addr"}, memAddr, v.addr[n]);
        chk({tag, "_wdata"}, memWData, v.wd[n]);
        if (memReady) n++;
      end else if (!memWe) begin
        chk({tag, "_addr_idle"}, memAddr, 32'h0);
      end
      if (v.poke && (k == 2 || k == 5)) begin
        start = 1'b1; baseAddr = 32'h900; stride = 32'h10; laneMask = 4'b0001;
        data = {4{32'hDEADBEEF}};
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; memReady = 1'b1;
    chk($sformatf("v%0d_nwrites", id), n, v.nwr);
  endtask

  initial begin
    vecs[0] = mk(4'b1111, 32'h100, 32'd4, 16'h0, 5, 4,
                 {32'h10C, 32'h108, 32'h104, 32'h100}, VDATA, 1'b0);
    vecs[1] = mk(4'b1010, 32'h200, 32'd8, 16'h0, 3, 2,
                 {64'h0, 32'h218, 32'h208}, {64'h0, 32'h44444444, 32'h22222222}, 1'b0);
    vecs[2] = mk(4'b1111, 32'h100, 32'd4, 16'h000C, 7, 4,
                 {32'h10C, 32'h108, 32'h104, 32'h100}, VDATA, 1'b0);
    vecs[3] = mk(4'b0000, 32'h300, 32'd4, 16'h0, 1, 0, 128'h0, 128'h0, 1'b0);
    vecs[4] = mk(4'b0011, 32'hFFFFFFFC, 32'd4, 16'h0, 3, 2,
                 {64'h0, 32'h00000000, 32'hFFFFFFFC}, {64'h0, 32'h22222222, 32'h11111111}, 1'b0);
    vecs[5] = mk(4'b1100, 32'h10, 32'd3, 16'h0, 3, 2,
                 {64'h0, 32'h19, 32'h16}, {64'h0, 32'h44444444, 32'h33333333}, 1'b0);
    vecs[6] = mk(4'b1111, 32'h100, 32'd4, 16'h0, 5, 4,
                 {32'h10C, 32'h108, 32'h104, 32'h100}, VDATA, 1'b1);

    rst_n = 1'b0; start = 1'b0; data = '0; baseAddr = '0; stride = '0;
    laneMask = '0; memReady = 1'b1;
    #1;
    chk("rst_we", {31'd0, memWe}, 32'd0);
    chk("rst_addr", memAddr, 32'd0);
    chk("rst_wdata", memWData, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Mid-operation reset: abort after lane 1 is presented.
    data = VDATA; baseAddr = 32'h100; stride = 32'd4; laneMask = 4'b1111;
    start = 1'b1; memReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mid_we_k1", {31'd0, memWe}, 32'd1);
    @(posedge clk); #1;
    chk("mid_addr_k2", memAddr, 32'h104);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, memWe}, 32'd0);
    chk("mid_rst_addr", memAddr, 32'd0);
    chk("mid_rst_wdata", memWData, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_we_%0d", k), {31'd0, memWe}, 32'd0);
      chk($sformatf("post_rst_busy_%0d", k), {31'd0, busy}, 32'd0);
    end
    run_vec(mk(4'b0001, 32'h40, 32'd4, 16'h0, 2, 1,
               {96'h0, 32'h40}, {96'h0, 32'h11111111}, 1'b0), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
